// File: rtl/dram_arbiter.sv
// rtl/dram_arbiter.sv - round-robin N-core arbiter onto a single-port synchronous data RAM
// Read data returns to its issuing core through a tag pipeline matched to the RAM latency.
module dram_arbiter #(
   parameter int N_CORES  = 4,
   parameter int ADDR_W   = 16,
   parameter int DATA_W   = 8,
   parameter int READ_LAT = 2
) (
   input  logic                        i_clk,
   input  logic                        i_rst,
   input  logic [N_CORES-1:0]          i_req,
   input  logic [N_CORES-1:0]          i_we,
   input  logic [N_CORES*ADDR_W-1:0]   i_addr,
   input  logic [N_CORES*DATA_W-1:0]   i_wdata,
   output logic [N_CORES-1:0]          o_gnt,
   output logic [N_CORES-1:0]          o_rvalid,
   output logic [DATA_W-1:0]           o_rdata,
   output logic [ADDR_W-1:0]           o_mem_addr,
   output logic [DATA_W-1:0]           o_mem_wdata,
   output logic                        o_mem_wren,
   output logic                        o_mem_rden,
   input  logic [DATA_W-1:0]           i_mem_q
);

   localparam int IDX_W = (N_CORES > 1) ? $clog2(N_CORES) : 1;

   logic [IDX_W-1:0]   ptr_q, ptr_d;
   logic [IDX_W-1:0]   gnt_idx;
   logic               gnt_any;
   logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0]  mem_wdata_q, mem_wdata_d;
   logic               mem_wren_q, mem_wren_d;
   logic               mem_rden_q, mem_rden_d;
   logic [READ_LAT:0]  tag_v_q;
   logic [IDX_W-1:0]   tag_idx_q [0:READ_LAT];
   logic [N_CORES-1:0] rvalid_q, rvalid_d;
   logic [DATA_W-1:0]  rdata_q;

   // Search starts one past the last winner, so the last winner has lowest priority.
   always_comb begin
      int k;
      k       = 0;
      gnt_any = 1'b0;
      gnt_idx = '0;
      for (int i = 1; i <= N_CORES; i++) begin
         k = (int'(ptr_q) + i) % N_CORES;
         if (!gnt_any && i_req[k]) begin
            gnt_any = 1'b1;
            gnt_idx = IDX_W'(k);
         end
      end
      if (i_rst) begin
         gnt_any = 1'b0;
      end
   end

   assign o_gnt = gnt_any ? (N_CORES'(1) << gnt_idx) : '0;

   always_comb begin
      ptr_d       = ptr_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      mem_wren_d  = 1'b0;
      mem_rden_d  = 1'b0;
      if (gnt_any) begin
         ptr_d       = gnt_idx;
         mem_addr_d  = i_addr[gnt_idx*ADDR_W +: ADDR_W];
         mem_wdata_d = i_wdata[gnt_idx*DATA_W +: DATA_W];
         mem_wren_d  = i_we[gnt_idx];
         mem_rden_d  = ~i_we[gnt_idx];
      end
      rvalid_d = '0;
      if (tag_v_q[READ_LAT]) begin
         rvalid_d[tag_idx_q[READ_LAT]] = 1'b1;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         ptr_q       <= IDX_W'(N_CORES - 1);
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         mem_wren_q  <= 1'b0;
         mem_rden_q  <= 1'b0;
         tag_v_q     <= '0;
         for (int s = 0; s <= READ_LAT; s++) begin
            tag_idx_q[s] <= '0;
         end
         rvalid_q    <= '0;
         rdata_q     <= '0;
      end else begin
         ptr_q       <= ptr_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         mem_wren_q  <= mem_wren_d;
         mem_rden_q  <= mem_rden_d;
         // Stage 0 is loaded alongside o_mem_rden; the last stage lines up with i_mem_q.
         tag_v_q      <= {tag_v_q[READ_LAT-1:0], mem_rden_d};
         tag_idx_q[0] <= gnt_idx;
         for (int s = 1; s <= READ_LAT; s++) begin
            tag_idx_q[s] <= tag_idx_q[s-1];
         end
         rvalid_q    <= rvalid_d;
         rdata_q     <= i_mem_q;
      end
   end

   assign o_mem_addr  = mem_addr_q;
   assign o_mem_wdata = mem_wdata_q;
   assign o_mem_wren  = mem_wren_q;
   assign o_mem_rden  = mem_rden_q;
   assign o_rvalid    = rvalid_q;
   assign o_rdata     = rdata_q;

endmodule
